// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the ALU arbiter.
// slave = arbiter side, master = requesters plus the shared ALU.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CTRL_W  = 4
);
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ-1:0][CTRL_W-1:0] req_ctrl_i;
    logic [NUM_REQ-1:0][WORD_W-1:0] req_op1_i;
    logic [NUM_REQ-1:0][WORD_W-1:0] req_op2_i;
    logic [NUM_REQ-1:0]             req_setf_i;
    logic [CTRL_W-1:0]              alu_ctrl_o;
    logic [WORD_W-1:0]              alu_op1_o;
    logic [WORD_W-1:0]              alu_op2_o;
    logic [WORD_W-1:0]              alu_result_i;
    logic [3:0]                     alu_status_i;
    logic [NUM_REQ-1:0]             rsp_valid_o;
    logic [NUM_REQ-1:0]             rsp_ready_i;
    logic [WORD_W-1:0]              rsp_result_o;
    logic [3:0]                     rsp_status_o;

    modport slave (
        input  req_valid_i, req_ctrl_i, req_op1_i, req_op2_i, req_setf_i,
        input  alu_result_i, alu_status_i, rsp_ready_i,
        output req_ready_o, alu_ctrl_o, alu_op1_o, alu_op2_o,
        output rsp_valid_o, rsp_result_o, rsp_status_o
    );

    modport master (
        output req_valid_i, req_ctrl_i, req_op1_i, req_op2_i, req_setf_i,
        output alu_result_i, alu_status_i, rsp_ready_i,
        input  req_ready_o, alu_ctrl_o, alu_op1_o, alu_op2_o,
        input  rsp_valid_o, rsp_result_o, rsp_status_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute-stage ALU between NUM_REQ requesters.
// Operands are latched at accept, result/flags registered after one EXEC cycle.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CTRL_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_arbiter_if.slave     bus,
    output logic [3:0]       nzcv_o,
    output logic             busy_o
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CTRL_W-1:0] ALU_ADD = '0;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, grant_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [WORD_W-1:0]  op1_q, op2_q, result_q;
    logic [3:0]         status_q, nzcv_q;
    logic               setf_q;

    logic               win_found;
    logic [GW-1:0]      win_idx;
    logic               accept;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!win_found && bus.req_valid_i[GW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            StIdle: accept = win_found;
            StExec: state_d = StResp;
            StResp: begin
                rsp_valid[grant_q] = 1'b1;
                if (bus.rsp_ready_i[grant_q]) begin
                    state_d = StIdle;
                    accept  = win_found;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            req_ready[win_idx] = 1'b1;
            state_d            = StExec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ctrl_q   <= ALU_ADD;
            op1_q    <= '0;
            op2_q    <= '0;
            setf_q   <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            nzcv_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ctrl_q   <= bus.req_ctrl_i[win_idx];
                op1_q    <= bus.req_op1_i[win_idx];
                op2_q    <= bus.req_op2_i[win_idx];
                setf_q   <= bus.req_setf_i[win_idx];
                grant_q  <= win_idx;
                rr_ptr_q <= (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (state_q == StExec) begin
                result_q <= bus.alu_result_i;
                status_q <= bus.alu_status_i;
                if (setf_q) begin
                    nzcv_q <= bus.alu_status_i;
                end
            end
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.alu_ctrl_o   = ctrl_q;
    assign bus.alu_op1_o    = op1_q;
    assign bus.alu_op2_o    = op2_q;
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_status_o = status_q;
    assign nzcv_o           = nzcv_q;
    assign busy_o           = (state_q != StIdle);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ADD/SUB ALU on the shared side.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] nzcv;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    alu_arbiter_if #(.NUM_REQ(2), .WORD_W(32), .CTRL_W(4)) bus ();

    alu_arbiter #(.NUM_REQ(2), .WORD_W(32), .CTRL_W(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .nzcv_o (nzcv),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // ALU: ctrl 0 = ADD, 1 = SUB (C = no borrow); status = {N, Z, C, V}
    always_comb begin
        logic [32:0] wide;
        logic [31:0] a, b;
        logic        v;
        a = bus.alu_op1_o;
        b = bus.alu_op2_o;
        if (bus.alu_ctrl_o == 4'd1) begin
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v    = (a[31] != b[31]) && (wide[31] != a[31]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            v    = (a[31] == b[31]) && (wide[31] != a[31]);
        end
        bus.alu_result_i = wide[31:0];
        bus.alu_status_i = {wide[31], (wide[31:0] == 32'd0), wide[32], v};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks happen 1 unit after that.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        bus.req_valid_i[r] = 1'b1;
        bus.req_ctrl_i[r]  = c;
        bus.req_op1_i[r]   = a;
        bus.req_op2_i[r]   = b;
        bus.req_setf_i[r]  = s;
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_r;
        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.req_ctrl_i  = '0;
        bus.req_op1_i   = '0;
        bus.req_op2_i   = '0;
        bus.req_setf_i  = '0;
        bus.rsp_ready_i = 2'b11;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rsp_valid", {30'd0, bus.rsp_valid_o}, 32'd0);
        check("reset_req_ready", {30'd0, bus.req_ready_o}, 32'd0);
        check("reset_nzcv", {28'd0, nzcv}, 32'd0);
        check("reset_result", bus.rsp_result_o, 32'd0);

        // 1: req0 ADD 5,7 setf
        set_req(0, 4'd0, 32'd5, 32'd7, 1'b1);
        settle();
        check("t1_ready", {30'd0, bus.req_ready_o}, 32'd1);
        cyc();
        bus.req_valid_i = '0;
        bus.req_op1_i[0] = 32'hDEAD_BEEF;
        settle();
        check("t1_exec_busy", {31'd0, busy}, 32'd1);
        check("t1_exec_no_rsp", {30'd0, bus.rsp_valid_o}, 32'd0);
        check("t1_exec_latched_op1", bus.alu_op1_o, 32'd5);
        cyc();
        settle();
        check("t1_rsp_valid", {30'd0, bus.rsp_valid_o}, 32'd1);
        check("t1_result", bus.rsp_result_o, 32'd12);
        check("t1_nzcv", {28'd0, nzcv}, 32'd0);
        cyc();

        // 5: req1 ADD 0x7FFFFFFF,1 setf -> overflow into sign
        set_req(1, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
        settle();
        check("t5_ready", {30'd0, bus.req_ready_o}, 32'd2);
        cyc();
        bus.req_valid_i = '0;
        cyc();
        settle();
        check("t5_rsp_valid", {30'd0, bus.rsp_valid_o}, 32'd2);
        check("t5_result", bus.rsp_result_o, 32'h8000_0000);
        check("t5_status", {28'd0, bus.rsp_status_o}, 32'h9);
        check("t5_nzcv", {28'd0, nzcv}, 32'h9);
        cyc();

        // 3: both requesters continuously valid -> grants alternate 0,1,0,1
        set_req(0, 4'd0, 32'd1, 32'd1, 1'b0);
        set_req(1, 4'd0, 32'd10, 32'd10, 1'b0);
        settle();
        check("t3_first_grant", {30'd0, bus.req_ready_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k % 2 == 0) ? 32'd2 : 32'd20;
            cyc();
            settle();
            check($sformatf("t3_exec_ready_%0d", k), {30'd0, bus.req_ready_o}, 32'd0);
            cyc();
            if (k == 3) bus.req_valid_i = '0;
            settle();
            check($sformatf("t3_rsp_valid_%0d", k), {30'd0, bus.rsp_valid_o}, {30'd0, exp_g});
            check($sformatf("t3_result_%0d", k), bus.rsp_result_o, exp_r);
            check($sformatf("t3_next_grant_%0d", k), {30'd0, bus.req_ready_o},
                  (k == 3) ? 32'd0 : {30'd0, ~exp_g});
        end
        cyc();
        settle();
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_nzcv_kept", {28'd0, nzcv}, 32'h9);

        // 2: req0 SUB 3,3 no setf -> Z in status, nzcv untouched
        set_req(0, 4'd1, 32'd3, 32'd3, 1'b0);
        settle();
        check("t2_ready", {30'd0, bus.req_ready_o}, 32'd1);
        cyc();
        bus.req_valid_i = '0;
        cyc();
        settle();
        check("t2_result", bus.rsp_result_o, 32'd0);
        check("t2_status", {28'd0, bus.rsp_status_o}, 32'h6);
        check("t2_nzcv", {28'd0, nzcv}, 32'h9);
        cyc();

        // 4: owner stalls response for 5 cycles while req1 waits
        bus.rsp_ready_i = 2'b10;
        set_req(0, 4'd0, 32'd100, 32'd23, 1'b0);
        settle();
        check("t4_ready0", {30'd0, bus.req_ready_o}, 32'd1);
        cyc();
        bus.req_valid_i[0] = 1'b0;
        set_req(1, 4'd0, 32'd1, 32'd2, 1'b0);
        settle();
        check("t4_exec_ready", {30'd0, bus.req_ready_o}, 32'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("t4_stall_valid_%0d", k), {30'd0, bus.rsp_valid_o}, 32'd1);
            check($sformatf("t4_stall_result_%0d", k), bus.rsp_result_o, 32'd123);
            check($sformatf("t4_stall_ready_%0d", k), {30'd0, bus.req_ready_o}, 32'd0);
            cyc();
        end
        bus.rsp_ready_i = 2'b01;
        settle();
        check("t4_accept_on_hs", {30'd0, bus.req_ready_o}, 32'd2);
        cyc();
        bus.req_valid_i = '0;
        cyc();
        bus.rsp_ready_i = 2'b11;
        settle();
        check("t4_rsp1_valid", {30'd0, bus.rsp_valid_o}, 32'd2);
        check("t4_rsp1_result", bus.rsp_result_o, 32'd3);
        cyc();

        // 6: reset during EXEC drops the op and clears flags
        set_req(0, 4'd1, 32'd1, 32'd2, 1'b1);
        cyc();
        bus.req_valid_i = '0;
        settle();
        check("t6_in_exec", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        cyc();
        settle();
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_rsp_valid", {30'd0, bus.rsp_valid_o}, 32'd0);
        check("t6_nzcv", {28'd0, nzcv}, 32'd0);
        check("t6_result", bus.rsp_result_o, 32'd0);
        check("t6_op1", bus.alu_op1_o, 32'd0);
        check("t6_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd0);
        rst = 1'b0;
        cyc();
        cyc();
        settle();
        check("t6_no_late_rsp", {30'd0, bus.rsp_valid_o}, 32'd0);
        check("t6_nzcv_after", {28'd0, nzcv}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
